// File: rtl/pipe_core_5s.sv
// rtl/pipe_core_5s.sv - four-stage in-order integer core with forwarding, load-use stall and flush
module pipe_core_5s #(
  parameter int DATA_W     = 64,
  parameter int NREGS      = 32,
  parameter int DMEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              flush,
  output logic              retire_valid,
  output logic [4:0]        retire_rt,
  output logic [DATA_W-1:0] retire_data,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUBF = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_ADDI = 3'd5;
  localparam logic [2:0] OP_LD   = 3'd6;
  localparam logic [2:0] OP_STD  = 3'd7;

  logic [DATA_W-1:0] rf   [NREGS];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  logic              id_valid;
  logic [31:0]       id_instr;
  logic [2:0]        id_op;
  logic [4:0]        id_rt, id_ra, id_rb;
  logic              id_use_ra, id_use_rb, id_use_rs;
  logic [DATA_W-1:0] id_imm, id_va, id_vb, id_vs;

  logic              ex_valid;
  logic [2:0]        ex_op;
  logic [4:0]        ex_rt, ex_ra, ex_rb;
  logic [DATA_W-1:0] ex_imm, ex_va, ex_vb, ex_vs;
  logic [DATA_W-1:0] ex_a, ex_b, ex_s, ex_alu;

  logic              mem_valid;
  logic [2:0]        mem_op;
  logic [4:0]        mem_rt;
  logic [DATA_W-1:0] mem_alu, mem_sdata, mem_result;
  logic [AW-1:0]     mem_addr;
  logic              mem_fwd_en;

  logic              wb_valid;
  logic [2:0]        wb_op;
  logic [4:0]        wb_rt;
  logic [DATA_W-1:0] wb_data;
  logic              wb_we;

  logic              load_use;

  // Indices at or above NREGS have no storage: they read 0 and never write.
  function automatic logic reg_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  function automatic logic writes_reg(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUBF, OP_AND, OP_OR, OP_ADDI, OP_LD};
  endfunction

  // Youngest producer wins: MEM stage first, then WB stage, then the value read in ID.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [4:0] idx, input logic [DATA_W-1:0] base,
    input logic m_en, input logic [4:0] m_rt, input logic [DATA_W-1:0] m_val,
    input logic w_en, input logic [4:0] w_rt, input logic [DATA_W-1:0] w_val);
    if (m_en && m_rt == idx) return m_val;
    if (w_en && w_rt == idx) return w_val;
    return base;
  endfunction

  // Decode the held ID instruction; bit 0 (record flag) is ignored for X-form ops.
  always_comb begin
    id_op = OP_NOP;
    case (id_instr[31:26])
      6'd31: begin
        case (id_instr[10:0]) inside
          {10'd266, 1'b?}: id_op = OP_ADD;
          {10'd40,  1'b?}: id_op = OP_SUBF;
          {10'd28,  1'b?}: id_op = OP_AND;
          {10'd444, 1'b?}: id_op = OP_OR;
          default:         id_op = OP_NOP;
        endcase
      end
      6'd14:   id_op = OP_ADDI;
      6'd58:   id_op = OP_LD;
      6'd62:   id_op = OP_STD;
      default: id_op = OP_NOP;
    endcase
  end

  assign id_rt     = id_instr[25:21];
  assign id_ra     = id_instr[20:16];
  assign id_rb     = id_instr[15:11];
  assign id_imm    = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
  assign id_use_ra = (id_op != OP_NOP);
  assign id_use_rb = id_op inside {OP_ADD, OP_SUBF, OP_AND, OP_OR};
  assign id_use_rs = (id_op == OP_STD);

  // Register read in ID sees the value being written back this same cycle.
  assign wb_we = wb_valid && writes_reg(wb_op) && reg_ok(wb_rt);
  assign id_va = (wb_we && wb_rt == id_ra) ? wb_data : (reg_ok(id_ra) ? rf[id_ra] : '0);
  assign id_vb = (wb_we && wb_rt == id_rb) ? wb_data : (reg_ok(id_rb) ? rf[id_rb] : '0);
  assign id_vs = (wb_we && wb_rt == id_rt) ? wb_data : (reg_ok(id_rt) ? rf[id_rt] : '0);

  // A load in EX cannot feed the instruction right behind it; hold ID for one cycle.
  assign load_use = id_valid && ex_valid && (ex_op == OP_LD) && reg_ok(ex_rt) &&
                    ((id_use_ra && id_ra == ex_rt) || (id_use_rb && id_rb == ex_rt) ||
                     (id_use_rs && id_rt == ex_rt));
  assign instr_ready = !load_use;

  assign mem_addr   = mem_alu[AW-1:0];
  assign mem_fwd_en = mem_valid && writes_reg(mem_op) && reg_ok(mem_rt);
  assign mem_result = (mem_op == OP_LD) ? dmem[mem_addr] : mem_alu;

  assign ex_a = fwd(ex_ra, ex_va, mem_fwd_en, mem_rt, mem_result, wb_we, wb_rt, wb_data);
  assign ex_b = fwd(ex_rb, ex_vb, mem_fwd_en, mem_rt, mem_result, wb_we, wb_rt, wb_data);
  assign ex_s = fwd(ex_rt, ex_vs, mem_fwd_en, mem_rt, mem_result, wb_we, wb_rt, wb_data);

  // Execute: ALU result, or effective address for loads and stores.
  always_comb begin
    ex_alu = '0;
    case (ex_op)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUBF:                ex_alu = ex_b - ex_a;
      OP_AND:                 ex_alu = ex_a & ex_b;
      OP_OR:                  ex_alu = ex_a | ex_b;
      OP_ADDI, OP_LD, OP_STD: ex_alu = ex_a + ex_imm;
      default:                ex_alu = '0;
    endcase
  end

  // ID stage: accept, hold on load-use, or drop everything on flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (!load_use) begin
      id_valid <= instr_valid;
      if (instr_valid) id_instr <= instr;
    end
  end

  // EX stage: takes ID contents, or a bubble on stall or flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_op    <= OP_NOP;
      ex_rt    <= '0;
      ex_ra    <= '0;
      ex_rb    <= '0;
      ex_imm   <= '0;
      ex_va    <= '0;
      ex_vb    <= '0;
      ex_vs    <= '0;
    end else begin
      ex_valid <= id_valid && !flush && !load_use;
      ex_op    <= id_op;
      ex_rt    <= id_rt;
      ex_ra    <= id_ra;
      ex_rb    <= id_rb;
      ex_imm   <= id_imm;
      ex_va    <= id_va;
      ex_vb    <= id_vb;
      ex_vs    <= id_vs;
    end
  end

  // MEM and WB stages: the instruction killed in EX by a flush never reaches MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_op    <= OP_NOP;
      mem_rt    <= '0;
      mem_alu   <= '0;
      mem_sdata <= '0;
      wb_valid  <= 1'b0;
      wb_op     <= OP_NOP;
      wb_rt     <= '0;
      wb_data   <= '0;
    end else begin
      mem_valid <= ex_valid && !flush;
      mem_op    <= ex_op;
      mem_rt    <= ex_rt;
      mem_alu   <= ex_alu;
      mem_sdata <= ex_s;
      wb_valid  <= mem_valid;
      wb_op     <= mem_op;
      wb_rt     <= mem_rt;
      wb_data   <= mem_result;
    end
  end

  // Register file: reset to index values, written at the edge ending WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= DATA_W'(i);
    end else if (wb_we) begin
      rf[wb_rt] <= wb_data;
    end
  end

  // Data memory: reset to index values, stores land at the edge ending MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DMEM_DEPTH; j++) dmem[j] <= DATA_W'(j);
    end else if (mem_valid && mem_op == OP_STD) begin
      dmem[mem_addr] <= mem_sdata;
    end
  end

  assign retire_valid = wb_valid && (wb_op != OP_NOP);
  assign retire_rt    = (wb_valid && writes_reg(wb_op)) ? wb_rt : '0;
  assign retire_data  = (wb_valid && writes_reg(wb_op)) ? wb_data : '0;
  assign dbg_data     = reg_ok(dbg_addr) ? rf[dbg_addr] : '0;

endmodule

// File: tb/tb_pipe_core_5s.sv
// tb/tb_pipe_core_5s.sv - scoreboard bench for pipe_core_5s against an architectural model
module tb_pipe_core_5s;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic          flush = 1'b0;
  logic          retire_valid;
  logic [4:0]    retire_rt;
  logic [DW-1:0] retire_data;
  logic [4:0]    dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  pipe_core_5s #(.DATA_W(DW), .NREGS(32), .DMEM_DEPTH(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .retire_valid(retire_valid),
    .retire_rt(retire_rt), .retire_data(retire_data), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rt;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] m_rf  [32];
  logic [DW-1:0] m_mem [32];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (reset && !instr_ready) stalls <= stalls + 1;

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && retire_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: rt=%0d data=%0h, required no retirement", retire_rt, retire_data);
      end else begin
        mon_e = sb.pop_front();
        if (retire_rt !== mon_e.rt || retire_data !== mon_e.data || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          n_err++;
          $display("FAIL retire: rt=%0d data=%0h cyc=%0d, required rt=%0d data=%0h cyc=%0d",
                   retire_rt, retire_data, cyc, mon_e.rt, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input int idx, input logic [DW-1:0] exp);
    dbg_addr = 5'(idx);
    #1;
    check(name, dbg_data, exp);
  endtask

  function automatic logic [31:0] enc_x(input int rt, input int ra, input int rb, input int xo);
    return {6'd31, 5'(rt), 5'(ra), 5'(rb), 10'(xo), 1'b0};
  endfunction

  function automatic logic [31:0] enc_d(input int op, input int rt, input int ra, input logic [15:0] d);
    return {6'(op), 5'(rt), 5'(ra), d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]  = DW'(i);
      m_mem[i] = DW'(i);
    end
    sb.delete();
  endtask

  task automatic push_exp(input int rt, input logic [DW-1:0] data, input int ecyc);
    exp_t e;
    e.rt = 5'(rt);
    e.data = data;
    e.cyc = ecyc;
    sb.push_back(e);
  endtask

  // Architectural execution of one instruction, in program order.
  task automatic model_exec(input logic [31:0] w, input int ecyc);
    int opcd, xo, rt, ra, rb;
    logic [DW-1:0] d, ea, v;
    opcd = int'(w[31:26]);
    xo   = int'(w[10:1]);
    rt   = int'(w[25:21]);
    ra   = int'(w[20:16]);
    rb   = int'(w[15:11]);
    d    = {{(DW-16){w[15]}}, w[15:0]};
    ea   = m_rf[ra] + d;
    if (opcd == 31 && xo inside {266, 40, 28, 444}) begin
      if (xo == 266)     v = m_rf[ra] + m_rf[rb];
      else if (xo == 40) v = m_rf[rb] - m_rf[ra];
      else if (xo == 28) v = m_rf[ra] & m_rf[rb];
      else               v = m_rf[ra] | m_rf[rb];
      m_rf[rt] = v;
      push_exp(rt, v, ecyc);
    end else if (opcd == 14) begin
      m_rf[rt] = ea;
      push_exp(rt, ea, ecyc);
    end else if (opcd == 58) begin
      v = m_mem[ea[4:0]];
      m_rf[rt] = v;
      push_exp(rt, v, ecyc);
    end else if (opcd == 62) begin
      m_mem[ea[4:0]] = m_rf[rt];
      push_exp(0, '0, ecyc);
    end
  endtask

  // Present one instruction until accepted; optionally model it, flush on the same edge, pin latency.
  task automatic issue(input logic [31:0] w, input bit mdl, input bit fl, input bit lat);
    int guard;
    guard = 0;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (!instr_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: instr_ready=0, required 1");
    end else begin
      flush = fl;
      if (mdl) model_exec(w, lat ? cyc + 4 : -1);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drain();
    instr_valid = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d retirements outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    int k, rt, ra, rb;
    logic [15:0] d;
    logic [31:0] w;
    int bad_op [8] = '{0, 1, 7, 13, 30, 32, 59, 63};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_retire_valid", 64'(retire_valid), 64'd0);
    check("reset_retire_rt", 64'(retire_rt), 64'd0);
    check("reset_retire_data", retire_data, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(instr_ready), 64'd1);
    check_reg("reset_r5", 5, 64'd5);

    // flush on the edge after acceptance kills addi r1,r0,9
    issue(enc_d(14, 1, 0, 16'd9), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    drain();
    check_reg("flush_r1", 1, 64'd1);

    // flush on the acceptance edge discards the instruction
    issue(enc_d(14, 2, 0, 16'd77), 1'b0, 1'b1, 1'b0);
    drain();
    check_reg("flush_accept_r2", 2, 64'd2);

    // flush during a load-use stall clears the stall and both instructions
    issue(enc_d(58, 3, 0, 16'd1), 1'b0, 1'b0, 1'b0);
    issue(enc_x(4, 3, 3, 266), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("stall_before_flush", 64'(instr_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("ready_after_flush", 64'(instr_ready), 64'd1);
    drain();
    check_reg("flush_stall_r3", 3, 64'd3);
    check_reg("flush_stall_r4", 4, 64'd4);

    // subf wraps; unknown encodings retire silently
    issue(enc_x(7, 8, 2, 40), 1'b1, 1'b0, 1'b0);
    issue(enc_d(5, 9, 1, 16'h1234), 1'b1, 1'b0, 1'b0);
    issue(enc_x(10, 1, 1, 100), 1'b1, 1'b0, 1'b0);
    drain();
    check_reg("subf_wrap_r7", 7, 64'hFFFF_FFFF_FFFF_FFFA);
    check_reg("nop_r9", 9, 64'd9);
    check_reg("nop_r10", 10, 64'd10);

    // back-to-back dependency through forwarding, fixed latency, no stall
    s0 = stalls;
    issue(enc_d(14, 1, 0, 16'd5), 1'b1, 1'b0, 1'b1);
    issue(enc_x(2, 1, 1, 266), 1'b1, 1'b0, 1'b1);
    drain();
    check("fwd_no_stall", 64'(stalls - s0), 64'd0);
    check_reg("fwd_r2", 2, 64'd10);

    // load-use: exactly one stall cycle
    s0 = stalls;
    issue(enc_d(58, 3, 0, 16'd2), 1'b1, 1'b0, 1'b0);
    issue(enc_x(4, 3, 3, 266), 1'b1, 1'b0, 1'b0);
    drain();
    check("load_use_stalls", 64'(stalls - s0), 64'd1);
    check_reg("load_use_r4", 4, 64'd4);

    // store then load of the same word
    issue(enc_d(62, 5, 0, 16'd7), 1'b1, 1'b0, 1'b0);
    issue(enc_d(58, 6, 0, 16'd7), 1'b1, 1'b0, 1'b0);
    drain();
    check_reg("st_ld_r6", 6, 64'd5);

    // reset with three instructions in flight
    issue(enc_d(62, 5, 0, 16'd9), 1'b0, 1'b0, 1'b0);
    issue(enc_d(14, 1, 0, 16'd33), 1'b0, 1'b0, 1'b0);
    issue(enc_x(2, 1, 1, 266), 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_mid_retire", 64'(retire_valid), 64'd0);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("ready_after_mid_reset", 64'(instr_ready), 64'd1);
    for (int i = 0; i < 32; i++) check_reg("mid_reset_reg", i, DW'(i));
    issue(enc_d(58, 9, 0, 16'd9), 1'b1, 1'b0, 1'b0);
    issue(enc_d(58, 6, 0, 16'd7), 1'b1, 1'b0, 1'b0);
    drain();

    // randomized mix with dense register reuse
    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      ra = $urandom_range(0, 7);
      rb = $urandom_range(0, 7);
      d  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
      case (k)
        0:       w = enc_x(rt, ra, rb, 266);
        1:       w = enc_x(rt, ra, rb, 40);
        2:       w = enc_x(rt, ra, rb, 28);
        3:       w = enc_x(rt, ra, rb, 444);
        4:       w = enc_d(14, rt, ra, d);
        5:       w = enc_d(58, rt, ra, d);
        6:       w = enc_d(62, rt, ra, d);
        default: w = ($urandom_range(0, 1) == 1) ? enc_d(bad_op[$urandom_range(0, 7)], rt, ra, d)
                                                 : enc_x(rt, ra, rb, 100);
      endcase
      issue(w, 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    drain();
    for (int i = 0; i < 32; i++) check_reg("final_reg", i, m_rf[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_core_5s.md
PIPE_CORE_5S -- requirements
Module: pipe_core_5s

Interface
REQ-001 Parameter DATA_W, default 64, datapath and register width.
REQ-002 Parameter NREGS, default 32, register count; register index 5 bits, entries at or above NREGS read 0 and ignore writes.
REQ-003 Parameter DMEM_DEPTH, default 32, data-memory words (power of 2); word index = low log2(DMEM_DEPTH) bits of effective address.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: instr  input  32  instruction word from external fetch.
REQ-007 Port: instr_valid  input  1  instr is valid this cycle.
REQ-008 Port: instr_ready  output  1  core accepts instr this cycle.
REQ-009 Port: flush  input  1  kill ID and EX contents at next edge.
REQ-010 Port: retire_valid  output  1  an instruction completes WB this cycle.
REQ-011 Port: retire_rt  output  5  destination register of retiring instruction (0 if none).
REQ-012 Port: retire_data  output  DATA_W  value written back (0 if none).
REQ-013 Port: dbg_addr  input  5  debug register select.
REQ-014 Port: dbg_data  output  DATA_W  combinational register-file read of dbg_addr, post-write value.

Function
REQ-015 Fields: OPCD[31:26], RT/RS[25:21], RA[20:16], RB[15:11], XO[10:1], D[15:0] sign-extended to DATA_W.
REQ-016 Supported: OPCD 31 with XO 266 add (RA+RB), XO 40 subf (RB-RA), XO 28 and, XO 444 or; OPCD 14 addi (RA+D); OPCD 58 ld (RT<=MEM[RA+D]); OPCD 62 std (MEM[RA+D]<=RS); any other encoding is a NOP, accepted and retired with retire_valid=0.
REQ-017 Arithmetic wraps modulo 2^DATA_W; no overflow flag, no exception.
REQ-018 Stages ID, EX, MEM, WB, each with a valid bit; handshake: transfer into ID when instr_valid && instr_ready at rising edge.
REQ-019 Latency: instruction accepted at edge k drives retire_valid=1 in cycle following edge k+3; register file updated at edge k+4.
REQ-020 Throughput: one instruction per cycle absent stalls; instr_ready=1 whenever no load-use stall is pending.
REQ-021 Forwarding into EX operands, priority EX/MEM over MEM/WB over register file; register 0 forwarded like any other.
REQ-022 Register file is write-before-read: ID read of register written in same cycle returns new value.
REQ-023 Load-use: ld in EX with RT matching a source of ID instruction -> instr_ready=0 one cycle, ID held, bubble into EX; exactly one stall cycle per hazard.
REQ-024 std data operand (RS) forwarded identically to RA/RB.
REQ-025 flush: at edge, ID and EX valid cleared; MEM and WB complete normally; flush and accept same edge -> accepted instruction discarded; flush during stall clears stall.
REQ-026 instr_valid=0 -> bubble enters ID; pipeline drains.
REQ-027 Store writes memory at edge ending MEM; ld in MEM after std in WB to same word reads stored value.

Reset
REQ-028 reset low: all stage valid bits 0, instr_ready=1 in cycle after release, retire_valid=0, retire_rt=0, retire_data=0.
REQ-029 reset low: register i <= i, memory word j <= j.
REQ-030 reset asserted mid-operation discards all in-flight instructions; no write after reset assertion.

Verification
REQ-031 addi r1,r0,5 then add r2,r1,r1 back-to-back -> r2=10 via EX/MEM forwarding, no stall, retire at cycles k+4,k+5.
REQ-032 ld r3,2(r0) then add r4,r3,r3 -> instr_ready low exactly one cycle, r4=4.
REQ-033 std r5,7(r0) then ld r6,7(r0) -> MEM[7]=5, r6=5.
REQ-034 addi r1,r0,9 accepted, flush asserted next edge -> r1 unchanged at 1, retire_valid never high for it.
REQ-035 Reset pulse while three instructions in flight -> registers and memory back to index values, no retire.
REQ-036 subf r7,r8,r2 (r8=8, r2=2) -> r7=2^DATA_W-6 (wrap), unknown opcode -> retire_valid=0.
